sha_result_check: RTL and testbench

- End-of-pipeline block for the SHA-256 miner. It is the counterpart of the pipeline-entry stage that loads W, H and the nonce.
- Takes the final working variables a..h after round 64, together with the H and nonce carried alongside them.
- Forms the digest, compares it against a target, and queues winning nonces in a small FIFO that the host drains with a valid/ready pop.
- Also counts checked hashes and keeps the last digest for debug readback.

---
 rtl/sha_result_check.sv | 131 +++++++++++++
 tb/tb_sha_result_check.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha_result_check.sv
// Final stage of the SHA-256 miner: adds H to the post-round working state, compares the
// digest against the target and queues winning nonces for the host to pop.
module sha_result_check #(
   parameter int WORD_S     = 32,
   parameter int H_SIZE     = 256,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 48
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              en,
   input  logic [H_SIZE-1:0] Hin,
   input  logic [H_SIZE-1:0] work,
   input  logic [WORD_S-1:0] nonce,
   input  logic [H_SIZE-1:0] target,
   input  logic              clr,
   output logic              out_valid,
   output logic [WORD_S-1:0] out_nonce,
   input  logic              out_ready,
   output logic              overflow,
   output logic [CNT_W-1:0]  hash_cnt,
   output logic [H_SIZE-1:0] last_digest
);

   localparam int N_WORDS = H_SIZE / WORD_S;
   localparam int AW      = $clog2(FIFO_DEPTH);
   localparam int CW      = AW + 1;

   logic [H_SIZE-1:0] w_sum;
   logic              r_s1_valid;
   logic [H_SIZE-1:0] r_s1_digest;
   logic [WORD_S-1:0] r_s1_nonce;

   logic [WORD_S-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;
   logic [WORD_S-1:0] r_out_nonce;
   logic              r_overflow;
   logic [CNT_W-1:0]  r_hash_cnt;
   logic [H_SIZE-1:0] r_last_digest;

   logic              w_found;
   logic              w_full;
   logic              w_pop;
   logic              w_push;
   logic              w_drop;
   logic [WORD_S-1:0] w_head_next;

   // Each 32-bit word is summed independently; carries never cross word boundaries.
   for (genvar g = 0; g < N_WORDS; g++) begin : g_add
      assign w_sum[g*WORD_S +: WORD_S] = Hin[g*WORD_S +: WORD_S] + work[g*WORD_S +: WORD_S];
   end

   // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_s1_valid  <= 1'b0;
         r_s1_digest <= '0;
         r_s1_nonce  <= '0;
      end else if (clr) begin
         r_s1_valid  <= 1'b0;
      end else begin
         r_s1_valid <= en;
         if (en) begin
            r_s1_digest <= w_sum;
            r_s1_nonce  <= nonce;
         end
      end
   end

   assign w_found = r_s1_valid && (r_s1_digest < target);
   assign w_full  = (r_count == CW'(FIFO_DEPTH));
   assign w_pop   = (r_count != '0) && out_ready;
   assign w_push  = w_found && (!w_full || w_pop);
   assign w_drop  = w_found && w_full && !w_pop;

   // Registered head so out_nonce keeps the last popped value once the FIFO drains.
   always_comb begin
      w_head_next = r_out_nonce;
      if (w_pop) begin
         if (r_count > CW'(1)) begin
            w_head_next = r_mem[r_rd_ptr + AW'(1)];
         end else if (w_push) begin
            w_head_next = r_s1_nonce;
         end
      end else if ((r_count == '0) && w_push) begin
         w_head_next = r_s1_nonce;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_count       <= '0;
         r_out_nonce   <= '0;
         r_overflow    <= 1'b0;
         r_hash_cnt    <= '0;
         r_last_digest <= '0;
      end else if (clr) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
         r_hash_cnt <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count     <= r_count + CW'(w_push) - CW'(w_pop);
         r_out_nonce <= w_head_next;
         if (w_drop) r_overflow <= 1'b1;
         if (r_s1_valid) begin
            r_last_digest <= r_s1_digest;
            r_hash_cnt    <= r_hash_cnt + CNT_W'(1);
         end
      end
   end

   // NOTE: storage array has no reset; the count and pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (w_push && !clr) r_mem[r_wr_ptr] <= r_s1_nonce;
   end

   assign out_valid   = (r_count != '0);
   assign out_nonce   = r_out_nonce;
   assign overflow    = r_overflow;
   assign hash_cnt    = r_hash_cnt;
   assign last_digest = r_last_digest;

endmodule

// File: tb/tb_sha_result_check.sv
// Randomised and directed bench for sha_result_check against a queue-based reference model.
module tb_sha_result_check;

   localparam int D = 4;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         en = 1'b0;
   logic         clr = 1'b0;
   logic         out_ready = 1'b0;
   logic [255:0] Hin = '0;
   logic [255:0] work = '0;
   logic [255:0] target = '0;
   logic [31:0]  nonce = '0;

   logic         out_valid, overflow;
   logic [31:0]  out_nonce;
   logic [47:0]  hash_cnt;
   logic [255:0] last_digest;

   logic         out_valid_w, overflow_w;
   logic [31:0]  out_nonce_w;
   logic [3:0]   hash_cnt_w;
   logic [255:0] last_digest_w;

   sha_result_check dut (
      .clk(clk), .reset_n(reset_n), .en(en), .Hin(Hin), .work(work), .nonce(nonce),
      .target(target), .clr(clr), .out_valid(out_valid), .out_nonce(out_nonce),
      .out_ready(out_ready), .overflow(overflow), .hash_cnt(hash_cnt), .last_digest(last_digest)
   );

   sha_result_check #(.CNT_W(4)) dut_w (
      .clk(clk), .reset_n(reset_n), .en(en), .Hin(Hin), .work(work), .nonce(nonce),
      .target(target), .clr(clr), .out_valid(out_valid_w), .out_nonce(out_nonce_w),
      .out_ready(out_ready), .overflow(overflow_w), .hash_cnt(hash_cnt_w), .last_digest(last_digest_w)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model: found-nonce queue plus a one-deep in-flight bundle.
   logic [31:0]  m_q[$];
   bit           m_s1_v;
   logic [255:0] m_s1_d;
   logic [31:0]  m_s1_n;
   logic [255:0] m_last;
   longint       m_cnt;
   bit           m_ovf;
   logic [31:0]  m_head;

   function automatic logic [255:0] add_words(input logic [255:0] a, input logic [255:0] b);
      logic [255:0] r;
      logic [31:0]  s;
      for (int i = 0; i < 8; i++) begin
         s = a[i*32 +: 32] + b[i*32 +: 32];
         r[i*32 +: 32] = s;
      end
      return r;
   endfunction

   function automatic logic [255:0] rnd256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_s1_v = 0; m_s1_d = '0; m_s1_n = '0;
      m_last = '0; m_cnt = 0; m_ovf = 0; m_head = '0;
   endtask

   task automatic model_edge();
      if (clr) begin
         m_q.delete();
         m_s1_v = 0; m_cnt = 0; m_ovf = 0;
         return;
      end
      if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
      if (m_s1_v) begin
         m_last = m_s1_d;
         m_cnt++;
         if (m_s1_d < target) begin
            if (m_q.size() < D) m_q.push_back(m_s1_n);
            else m_ovf = 1;
         end
      end
      m_s1_v = en;
      if (en) begin
         m_s1_d = add_words(Hin, work);
         m_s1_n = nonce;
      end
      if (m_q.size() > 0) m_head = m_q[0];
   endtask

   task automatic compare_all();
      logic [63:0] c;
      c = 64'(m_cnt);
      check("out_valid", out_valid, m_q.size() != 0);
      check("out_nonce", out_nonce, m_head);
      check("overflow", overflow, m_ovf);
      check("hash_cnt", hash_cnt, c[47:0]);
      check("last_digest", last_digest, m_last);
      check("w_out_valid", out_valid_w, m_q.size() != 0);
      check("w_out_nonce", out_nonce_w, m_head);
      check("w_overflow", overflow_w, m_ovf);
      check("w_hash_cnt", hash_cnt_w, c[3:0]);
      check("w_last_digest", last_digest_w, m_last);
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic drain_expect(input logic [31:0] v);
      check("drain_valid", out_valid, 1'b1);
      check("drain_nonce", out_nonce, v);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic do_clr();
      en = 1'b0;
      clr = 1'b1;
      step();
      clr = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, out_valid, 1'b0);
      check({tag, "_nonce"}, out_nonce, 32'd0);
      check({tag, "_ovf"}, overflow, 1'b0);
      check({tag, "_cnt"}, hash_cnt, 48'd0);
      check({tag, "_digest"}, last_digest, 256'd0);
      check({tag, "_cnt_w"}, hash_cnt_w, 4'd0);
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      reset_n = 1'b1;

      // Single found: digest is all zero, target 1.
      Hin = {8{32'h0000_0001}};
      work = {8{32'hFFFF_FFFF}};
      target = 256'd1;
      nonce = 32'hDEAD_BEEF;
      en = 1'b1;
      step();
      en = 1'b0;
      check("single_early", out_valid, 1'b0);
      step();
      check("single_valid", out_valid, 1'b1);
      check("single_nonce", out_nonce, 32'hDEAD_BEEF);
      check("single_cnt", hash_cnt, 48'd1);
      check("single_digest", last_digest, 256'd0);
      drain_expect(32'hDEAD_BEEF);
      check("single_empty", out_valid, 1'b0);

      // Equal target is a miss; target one above the digest is a hit.
      Hin = '0;
      work = {32'h8000_0000, 224'd0};
      target = {32'h8000_0000, 224'd0};
      nonce = 32'h11;
      en = 1'b1; step(); en = 1'b0; step();
      check("eq_nopush", out_valid, 1'b0);
      check("eq_cnt", hash_cnt, 48'd2);
      target = {32'h8000_0000, 224'd1};
      nonce = 32'h22;
      en = 1'b1; step(); en = 1'b0; step();
      check("lt_push", out_valid, 1'b1);
      check("lt_nonce", out_nonce, 32'h22);
      drain_expect(32'h22);

      // Word-local wrap: 0x80000000 + 0x80000000 leaves word1 untouched.
      Hin = {32'h8000_0000, 224'd0};
      work = {32'h8000_0000, 224'd0};
      target = '1;
      nonce = 32'h33;
      en = 1'b1; step(); en = 1'b0; step();
      check("wrap_digest", last_digest, 256'd0);
      drain_expect(32'h33);

      // Overflow: six hits into a four-entry FIFO with no pops.
      do_clr();
      target = '1;
      for (int i = 1; i <= 6; i++) begin
         nonce = 32'(i);
         en = 1'b1;
         step();
      end
      en = 1'b0;
      step(); step();
      check("ovf_flag", overflow, 1'b1);
      for (int k = 1; k <= 4; k++) drain_expect(32'(k));
      check("ovf_empty", out_valid, 1'b0);

      // Full FIFO with simultaneous push and pop.
      do_clr();
      for (int i = 1; i <= 5; i++) begin
         nonce = 32'(i);
         en = 1'b1;
         step();
      end
      en = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("fpp_ovf", overflow, 1'b0);
      for (int k = 2; k <= 5; k++) drain_expect(32'(k));
      check("fpp_empty", out_valid, 1'b0);

      // clr with two queued entries and a hit in flight.
      do_clr();
      nonce = 32'h7; en = 1'b1; step();
      nonce = 32'h8; step();
      en = 1'b0; step();
      nonce = 32'h9; en = 1'b1; step();
      en = 1'b0; clr = 1'b1; step();
      clr = 1'b0;
      check("clr_valid", out_valid, 1'b0);
      check("clr_cnt", hash_cnt, 48'd0);
      repeat (3) step();
      check("clr_nosurvive", out_valid, 1'b0);

      // Counter wrap on the 4-bit instance.
      do_clr();
      target = '0;
      en = 1'b1;
      for (int i = 0; i < 17; i++) begin
         Hin = rnd256(); work = rnd256(); nonce = $urandom;
         step();
      end
      en = 1'b0;
      step();
      check("cntwrap_small", hash_cnt_w, 4'd1);
      check("cntwrap_big", hash_cnt, 48'd17);

      // Randomised traffic, with an asynchronous reset dropped mid-stream.
      for (int i = 0; i < 600; i++) begin
         en = ($urandom_range(0, 3) != 0);
         Hin = rnd256();
         work = rnd256();
         nonce = $urandom;
         target = rnd256();
         target[255:224] = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 32'h3FFF_FFFF));
         out_ready = ($urandom_range(0, 2) == 0);
         clr = ($urandom_range(0, 99) == 0);
         step();
         if (i == 300) begin
            #2;
            reset_n = 1'b0;
            #1;
            check_all_zero("async");
            model_reset();
            en = 1'b0; clr = 1'b0; out_ready = 1'b0;
            @(posedge clk);
            #1;
            check_all_zero("async_hold");
            reset_n = 1'b1;
         end
      end
      en = 1'b0; clr = 1'b0; out_ready = 1'b0;
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
